// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: collects serial (A,B) FP16 operand pairs into a flat
// LANES-wide vector and presents it to the MAC array for HOLD_CYCLES cycles,
// driving zeros otherwise. A staging bank plus an output bank allow a new
// vector to fill while the previous one is being presented.
module pe_operand_feeder #(
  parameter int unsigned LANES       = 49,
  parameter int unsigned DW          = 16,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_a,
  input  logic [DW-1:0]         in_b,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [LANES*DW-1:0]   A_inputs,
  output logic [LANES*DW-1:0]   B_inputs,
  output logic [15:0]           vec_cnt
);

  localparam int unsigned VW = LANES * DW;
  localparam int unsigned IW = (LANES < 2) ? 1 : $clog2(LANES);
  localparam int unsigned HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  logic [IW-1:0] wr_idx;
  logic [HW-1:0] hold_cnt;
  logic [VW-1:0] stage_a;
  logic [VW-1:0] stage_b;
  logic [VW-1:0] merged_a_c;
  logic [VW-1:0] merged_b_c;
  logic          load_ok_c;
  logic          at_last_c;
  logic          accept_c;
  logic          issue_c;

  // Handshake, issue decision, and staging contents including this edge's pair
  always_comb begin
    load_ok_c  = (hold_cnt <= HW'(1));
    at_last_c  = (wr_idx == LAST_IDX);
    in_ready   = rst && !((at_last_c || flush) && !load_ok_c);
    accept_c   = in_valid && in_ready;
    // A full-vector accept already implies load_ok via in_ready; flush must
    // wait for the output bank explicitly since it may fire without an accept.
    issue_c    = (accept_c && at_last_c) ||
                 (flush && load_ok_c && ((wr_idx != '0) || accept_c));
    merged_a_c = stage_a;
    merged_b_c = stage_b;
    for (int k = 0; k < LANES; k++) begin
      if (accept_c && (wr_idx == IW'(k))) begin
        merged_a_c[k*DW +: DW] = in_a;
        merged_b_c[k*DW +: DW] = in_b;
      end
    end
  end

  // Staging bank and write pointer; cleared on every issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_a <= '0;
      stage_b <= '0;
      wr_idx  <= '0;
    end else if (issue_c) begin
      stage_a <= '0;
      stage_b <= '0;
      wr_idx  <= '0;
    end else if (accept_c) begin
      stage_a <= merged_a_c;
      stage_b <= merged_b_c;
      wr_idx  <= wr_idx + IW'(1);
    end
  end

  // Output bank: load on issue, hold for HOLD_CYCLES, then return to zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      A_inputs  <= '0;
      B_inputs  <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      vec_cnt   <= '0;
    end else if (issue_c) begin
      A_inputs  <= merged_a_c;
      B_inputs  <= merged_b_c;
      hold_cnt  <= HW'(HOLD_CYCLES);
      out_valid <= 1'b1;
      vec_cnt   <= vec_cnt + 16'd1;
    end else if (hold_cnt != '0) begin
      hold_cnt  <= hold_cnt - HW'(1);
      out_valid <= (hold_cnt != HW'(1));
      if (hold_cnt == HW'(1)) begin
        A_inputs <= '0;
        B_inputs <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3, both fed from the same operand stream.
module tb_pe_operand_feeder;

  localparam int unsigned LANES = 49;
  localparam int unsigned DW    = 16;
  localparam int unsigned VW    = LANES * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          flush;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;

  logic          rdy1, ov1, rdy3, ov3;
  logic [VW-1:0] a1, b1, a3, b3;
  logic [15:0]   cnt1, cnt3;

  pe_operand_feeder #(.LANES(LANES), .DW(DW), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ov1),
    .A_inputs(a1), .B_inputs(b1), .vec_cnt(cnt1)
  );

  pe_operand_feeder #(.LANES(LANES), .DW(DW), .HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ov3),
    .A_inputs(a3), .B_inputs(b3), .vec_cnt(cnt3)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } vec_t;

  vec_t q1[$];
  int   runs3[$];
  int   run3 = 0;

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] a;
    logic        f;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_cnt;
    logic [15:0] e_l0;
    logic [15:0] e_l1;
  } row_t;

  // Capture every presented vector of the HOLD=1 instance
  always @(negedge clk) begin
    if (ov1 === 1'b1) q1.push_back({a1, b1});
  end

  // Record the length of each out_valid run of the HOLD=3 instance
  always @(negedge clk) begin
    if (ov3 === 1'b1) run3++;
    else if (run3 > 0) begin
      runs3.push_back(run3);
      run3 = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int k = 0; k < LANES; k++) begin
        if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s lane %0d: got 0x%0h expected 0x%0h",
                   name, k, act[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] mk(input int n, input int base, input int step);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*DW +: DW] = DW'(base + step * k);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair and wait (bounded) until the HOLD=1 instance takes it
  task automatic push(input int a, input int b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = DW'(a);
    in_b     = DW'(b);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = (rdy1 === 1'b1);
      cyc();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: pair 0x%0h never accepted", a);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_a     = '0;
    in_b     = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t tbl[14];

    // Reset state, with in_valid asserted to show in_ready stays low
    rst      = 1'b0;
    in_valid = 1'b1;
    flush    = 1'b0;
    in_a     = 16'h1234;
    in_b     = 16'h5678;
    cyc();
    @(negedge clk);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    chk("rst_ready3", 32'(rdy3), 32'd0);
    chk("rst_valid", 32'(ov1), 32'd0);
    chk_vec("rst_a", a1, '0);
    chk_vec("rst_b", b1, '0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(rdy1), 32'd1);
    cyc();

    // Full vector, HOLD=1 and HOLD=3 in parallel
    for (int k = 0; k < 49; k++) push(k, 16'h3C00);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_valid", 32'(ov1), 32'd1);
    chk_vec("full_a", a1, mk(49, 0, 1));
    chk_vec("full_b", b1, mk(49, 16'h3C00, 0));
    chk("full_cnt", 32'(cnt1), 32'd1);
    chk("full_valid3_c1", 32'(ov3), 32'd1);
    @(negedge clk);
    chk("full_after_valid", 32'(ov1), 32'd0);
    chk_vec("full_after_a", a1, '0);
    chk_vec("full_after_b", b1, '0);
    chk("full_after_cnt", 32'(cnt1), 32'd1);
    chk("full_valid3_c2", 32'(ov3), 32'd1);
    @(negedge clk);
    chk("full_valid3_c3", 32'(ov3), 32'd1);
    chk_vec("full_a3", a3, mk(49, 0, 1));
    @(negedge clk);
    chk("full_valid3_end", 32'(ov3), 32'd0);
    chk_vec("full_a3_end", a3, '0);
    chk("full_cnt3", 32'(cnt3), 32'd1);
    cyc();

    // Two vectors streamed back to back
    q1.delete();
    runs3.delete();
    for (int k = 0; k < 98; k++) push(100 + k, 7 + 2 * k);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stream_nvec", 32'(q1.size()), 32'd2);
    if (q1.size() >= 2) begin
      chk_vec("stream_v0_a", q1[0].a, mk(49, 100, 1));
      chk_vec("stream_v0_b", q1[0].b, mk(49, 7, 2));
      chk_vec("stream_v1_a", q1[1].a, mk(49, 149, 1));
      chk_vec("stream_v1_b", q1[1].b, mk(49, 105, 2));
    end
    chk("stream_cnt1", 32'(cnt1), 32'd3);
    chk("stream_cnt3", 32'(cnt3), 32'd3);
    chk("stream_runs3", 32'(runs3.size()), 32'd2);
    if (runs3.size() >= 2) begin
      chk("stream_run0_len", 32'(runs3[0]), 32'd3);
      chk("stream_run1_len", 32'(runs3[1]), 32'd3);
    end
    cyc();

    // Partial vector flushed, then a flush with nothing staged
    for (int k = 0; k < 10; k++) push(16'h1000 + k, 16'h2000 + k);
    in_valid = 1'b0;
    flush    = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(ov1), 32'd1);
    chk_vec("flush_a", a1, mk(10, 16'h1000, 1));
    chk_vec("flush_b", b1, mk(10, 16'h2000, 1));
    chk("flush_cnt", 32'(cnt1), 32'd4);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", 32'(ov1), 32'd0);
    chk("flush_empty_cnt", 32'(cnt1), 32'd4);
    cyc();

    // HOLD=1: accept+flush at the same edge, re-issued on the presentation cycle
    do_reset();
    in_valid = 1'b1;
    in_a     = 16'h0007;
    in_b     = 16'h0000;
    flush    = 1'b1;
    cyc();
    in_a = 16'h0008;
    @(negedge clk);
    chk("cont_ready", 32'(rdy1), 32'd1);
    chk("cont_valid0", 32'(ov1), 32'd1);
    chk_vec("cont_a0", a1, mk(1, 7, 0));
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("cont_valid1", 32'(ov1), 32'd1);
    chk_vec("cont_a1", a1, mk(1, 8, 0));
    chk("cont_cnt", 32'(cnt1), 32'd2);
    @(negedge clk);
    chk("cont_valid2", 32'(ov1), 32'd0);
    cyc();

    // HOLD=3: flush stall while the output bank is busy, then reset mid-fill
    do_reset();
    //          r     v     a       f     rdy   ov    cnt    l0     l1
    tbl[0]  = '{1'b1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 16'd2};
    tbl[3]  = '{1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 16'd2};
    tbl[4]  = '{1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 16'd2};
    tbl[5]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd3, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd3, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd3, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0};
    tbl[10] = '{1'b1, 1'b1, 16'd9, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 16'd0};
    tbl[12] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0};
    tbl[13] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 14; i++) begin
      rst      = tbl[i].r;
      in_valid = tbl[i].v;
      in_a     = tbl[i].a;
      in_b     = 16'h0000;
      flush    = tbl[i].f;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy3), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(ov3), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt3), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_lane0", i), 32'(a3[15:0]), 32'(tbl[i].e_l0));
      chk($sformatf("tbl%0d_lane1", i), 32'(a3[31:16]), 32'(tbl[i].e_l1));
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // Random input gaps must not change the issued vectors
    do_reset();
    q1.delete();
    for (int k = 0; k < 147; k++) begin
      repeat ($urandom_range(0, 1)) begin
        in_valid = 1'b0;
        cyc();
      end
      push(1 + 3 * k, 16'hA000 + k);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("gap_nvec", 32'(q1.size()), 32'd3);
    if (q1.size() >= 3) begin
      for (int j = 0; j < 3; j++) begin
        chk_vec($sformatf("gap_v%0d_a", j), q1[j].a, mk(49, 1 + 147 * j, 3));
        chk_vec($sformatf("gap_v%0d_b", j), q1[j].b, mk(49, 16'hA000 + 49 * j, 1));
      end
    end
    chk("gap_cnt", 32'(cnt1), 32'd3);
    cyc();

    // Reset after a partial fill discards the staged lanes
    do_reset();
    q1.delete();
    for (int k = 0; k < 20; k++) push(16'h7000 + k, 16'h7100 + k);
    in_valid = 1'b0;
    rst      = 1'b0;
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 49; k++) push(16'h5000 + k, 16'h6000 + k);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstfill_nvec", 32'(q1.size()), 32'd1);
    if (q1.size() >= 1) begin
      chk_vec("rstfill_a", q1[0].a, mk(49, 16'h5000, 1));
      chk_vec("rstfill_b", q1[0].b, mk(49, 16'h6000, 1));
    end
    chk("rstfill_cnt", 32'(cnt1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
